// File: rtl/tpu_instruction_dispatcher.sv
// rtl/tpu_instruction_dispatcher.sv - instruction dispatcher: decode, hazard resolve, issue to TPU units

package tpu_pkg;
   typedef struct packed {
      logic [7:0]  opcode;
      logic [31:0] calc_length;
      logic [15:0] acc_address;
      logic [23:0] buffer_address;
   } instr_type;

   localparam instr_type INIT_INSTR = '0;
endpackage

module tpu_instruction_dispatcher
   import tpu_pkg::*;
#(
   parameter int MATRIX_WIDTH = 14,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  instr_type            instr_in,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   output instr_type            weight_instr,
   output logic                 weight_instr_enable,
   input  logic                 weight_busy,
   input  logic                 weight_resource_busy,
   output instr_type            mmu_instr,
   output logic                 mmu_instr_enable,
   input  logic                 mmu_busy,
   input  logic                 mmu_resource_busy,
   output instr_type            act_instr,
   output logic                 act_instr_enable,
   input  logic                 act_busy,
   input  logic                 act_resource_busy,
   output logic                 synchronize,
   output logic                 busy,
   output logic                 halted,
   output logic                 illegal_opcode,
   output logic [CNT_WIDTH-1:0] issued_count
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      SYNC_WAIT = 2'd2,
      HALTED    = 2'd3
   } state_t;

   // The array dimension only shapes package-typed widths upstream; reject nonsense values early.
   if (MATRIX_WIDTH < 1) begin : g_bad_matrix_width
      $error("MATRIX_WIDTH must be positive");
   end

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   state_t    state;
   instr_type held;
   logic      zero_len;

   assign instr_ready = (state == IDLE) & enable & ~halted & rst;
   assign busy        = (state != IDLE);
   assign zero_len    = (held.calc_length == 32'd0);

   // Single FSM: accept into the hold register, then issue once the target unit's hazards clear.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state               <= IDLE;
         held                <= INIT_INSTR;
         weight_instr        <= INIT_INSTR;
         mmu_instr           <= INIT_INSTR;
         act_instr           <= INIT_INSTR;
         weight_instr_enable <= 1'b0;
         mmu_instr_enable    <= 1'b0;
         act_instr_enable    <= 1'b0;
         synchronize         <= 1'b0;
         halted              <= 1'b0;
         illegal_opcode      <= 1'b0;
         issued_count        <= '0;
      end else begin
         weight_instr_enable <= 1'b0;
         mmu_instr_enable    <= 1'b0;
         act_instr_enable    <= 1'b0;
         synchronize         <= 1'b0;
         if (enable) begin
            case (state)
               IDLE: begin
                  if (instr_valid && !halted) begin
                     held  <= instr_in;
                     state <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (held.opcode == 8'hFF) begin
                     halted <= 1'b1;
                     state  <= HALTED;
                  end else begin
                     case (held.opcode[7:4])
                        4'h0: begin
                           if (held.opcode == 8'h00) begin
                              state <= IDLE;
                           end else if (held.opcode == 8'h01) begin
                              state <= SYNC_WAIT;
                           end else begin
                              illegal_opcode <= 1'b1;
                              state          <= IDLE;
                           end
                        end
                        4'h2: begin
                           if (zero_len) begin
                              state <= IDLE;
                           end else if (!mmu_resource_busy && !weight_busy) begin
                              mmu_instr        <= held;
                              mmu_instr_enable <= 1'b1;
                              issued_count     <= issued_count + CNT_ONE;
                              state            <= IDLE;
                           end
                        end
                        4'h4: begin
                           if (zero_len) begin
                              state <= IDLE;
                           end else if (!weight_resource_busy) begin
                              weight_instr        <= held;
                              weight_instr_enable <= 1'b1;
                              issued_count        <= issued_count + CNT_ONE;
                              state               <= IDLE;
                           end
                        end
                        4'h8: begin
                           if (zero_len) begin
                              state <= IDLE;
                           end else if (!act_resource_busy && !mmu_busy) begin
                              act_instr        <= held;
                              act_instr_enable <= 1'b1;
                              issued_count     <= issued_count + CNT_ONE;
                              state            <= IDLE;
                           end
                        end
                        default: begin
                           illegal_opcode <= 1'b1;
                           state          <= IDLE;
                        end
                     endcase
                  end
               end
               SYNC_WAIT: begin
                  if (!weight_busy && !mmu_busy && !act_busy) begin
                     synchronize <= 1'b1;
                     state       <= IDLE;
                  end
               end
               HALTED: begin
                  state <= HALTED;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tpu_instruction_dispatcher.sv
// tb/tb_tpu_instruction_dispatcher.sv - directed table-driven bench for tpu_instruction_dispatcher

module tb_tpu_instruction_dispatcher;
   import tpu_pkg::*;

   logic      clk = 1'b0;
   logic      rst = 1'b0;
   logic      enable = 1'b1;
   instr_type instr_in = INIT_INSTR;
   logic      instr_valid = 1'b0;
   logic      instr_ready;
   instr_type weight_instr, mmu_instr, act_instr;
   logic      weight_instr_enable, mmu_instr_enable, act_instr_enable;
   logic      weight_busy = 1'b0, weight_resource_busy = 1'b0;
   logic      mmu_busy = 1'b0, mmu_resource_busy = 1'b0;
   logic      act_busy = 1'b0, act_resource_busy = 1'b0;
   logic      synchronize, busy, halted, illegal_opcode;
   logic [3:0] issued_count;

   int total = 0;
   int bad   = 0;
   logic [3:0] exp_count = 4'd0;

   always #5 clk = ~clk;

   tpu_instruction_dispatcher #(.MATRIX_WIDTH(14), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .weight_instr(weight_instr), .weight_instr_enable(weight_instr_enable),
      .weight_busy(weight_busy), .weight_resource_busy(weight_resource_busy),
      .mmu_instr(mmu_instr), .mmu_instr_enable(mmu_instr_enable),
      .mmu_busy(mmu_busy), .mmu_resource_busy(mmu_resource_busy),
      .act_instr(act_instr), .act_instr_enable(act_instr_enable),
      .act_busy(act_busy), .act_resource_busy(act_resource_busy),
      .synchronize(synchronize), .busy(busy), .halted(halted),
      .illegal_opcode(illegal_opcode), .issued_count(issued_count)
   );

   typedef struct {
      instr_type  instr;
      logic [1:0] target;   // 0 none, 1 weight, 2 mmu, 3 act
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic instr_type mk(input logic [7:0] op, input logic [31:0] len,
                                    input logic [15:0] acc, input logic [23:0] buffer);
      instr_type t;
      t.opcode = op; t.calc_length = len; t.acc_address = acc; t.buffer_address = buffer;
      return t;
   endfunction

   task automatic check_enables(input string name, input logic [1:0] target);
      chk({name, "_wen"}, 80'(weight_instr_enable), 80'(target == 2'd1));
      chk({name, "_men"}, 80'(mmu_instr_enable),    80'(target == 2'd2));
      chk({name, "_aen"}, 80'(act_instr_enable),    80'(target == 2'd3));
   endtask

   // Present one word and complete the handshake on the next edge.
   task automatic send(input string name, input instr_type i);
      instr_in    = i;
      instr_valid = 1'b1;
      chk({name, "_ready"}, 80'(instr_ready), 80'd1);
      cyc();
      instr_valid = 1'b0;
   endtask

   initial begin
      vecs[0] = '{mk(8'h23, 32'd29, 16'h0049, 24'h009463), 2'd2};
      vecs[1] = '{mk(8'h41, 32'd14, 16'h0010, 24'h000100), 2'd1};
      vecs[2] = '{mk(8'h81, 32'd7,  16'h0020, 24'h000200), 2'd3};
      vecs[3] = '{mk(8'h00, 32'd0,  16'h0000, 24'h000000), 2'd0};
      vecs[4] = '{mk(8'h21, 32'd0,  16'h0033, 24'h000444), 2'd0};
      vecs[5] = '{mk(8'h45, 32'd1,  16'h1234, 24'habcdef), 2'd1};

      // Reset held for two cycles with a valid word on the bus.
      rst = 1'b0;
      instr_valid = 1'b1;
      instr_in = vecs[0].instr;
      #1;
      chk("rst_ready_comb", 80'(instr_ready), 80'd0);
      cyc();
      cyc();
      chk("rst_ready", 80'(instr_ready), 80'd0);
      check_enables("rst", 2'd0);
      chk("rst_count", 80'(issued_count), 80'd0);
      chk("rst_winstr", 80'(weight_instr), 80'(INIT_INSTR));
      chk("rst_minstr", 80'(mmu_instr), 80'(INIT_INSTR));
      chk("rst_ainstr", 80'(act_instr), 80'(INIT_INSTR));
      chk("rst_flags", 80'({synchronize, busy, halted, illegal_opcode}), 80'd0);
      instr_valid = 1'b0;
      rst = 1'b1;
      #1;

      // Table of single instructions with no hazards.
      for (int k = 0; k < 6; k++) begin
         send($sformatf("v%0d", k), vecs[k].instr);
         chk($sformatf("v%0d_busy", k), 80'(busy), 80'd1);
         cyc();
         check_enables($sformatf("v%0d", k), vecs[k].target);
         if (vecs[k].target != 2'd0) exp_count = exp_count + 4'd1;
         chk($sformatf("v%0d_count", k), 80'(issued_count), 80'(exp_count));
         case (vecs[k].target)
            2'd1: chk($sformatf("v%0d_winstr", k), 80'(weight_instr), 80'(vecs[k].instr));
            2'd2: chk($sformatf("v%0d_minstr", k), 80'(mmu_instr), 80'(vecs[k].instr));
            2'd3: chk($sformatf("v%0d_ainstr", k), 80'(act_instr), 80'(vecs[k].instr));
            default: ;
         endcase
         cyc();
         check_enables($sformatf("v%0d_after", k), 2'd0);
         chk($sformatf("v%0d_ready_after", k), 80'(instr_ready), 80'd1);
      end
      chk("mmu_instr_kept", 80'(mmu_instr), 80'(vecs[0].instr));

      // MATMUL waits on weight_busy.
      weight_busy = 1'b1;
      send("mm_wb", vecs[0].instr);
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("mm_wb_hold%0d", k), 80'(mmu_instr_enable), 80'd0);
      end
      weight_busy = 1'b0;
      cyc();
      check_enables("mm_wb_issue", 2'd2);
      exp_count = exp_count + 4'd1;
      chk("mm_wb_count", 80'(issued_count), 80'(exp_count));
      cyc();

      // LOAD_WEIGHT issues, ACTIVATE blocked by mmu_busy.
      mmu_busy = 1'b1;
      send("lw", vecs[1].instr);
      cyc();
      check_enables("lw_issue", 2'd1);
      exp_count = exp_count + 4'd1;
      cyc();
      send("act_mb", vecs[2].instr);
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk($sformatf("act_mb_hold%0d", k), 80'(act_instr_enable), 80'd0);
         chk($sformatf("act_mb_ready%0d", k), 80'(instr_ready), 80'd0);
      end
      mmu_busy = 1'b0;
      cyc();
      check_enables("act_mb_issue", 2'd3);
      exp_count = exp_count + 4'd1;
      chk("act_mb_count", 80'(issued_count), 80'(exp_count));
      cyc();

      // enable low defers a ready issue without losing it.
      send("frz", vecs[5].instr);
      enable = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         check_enables($sformatf("frz_hold%0d", k), 2'd0);
      end
      chk("frz_count", 80'(issued_count), 80'(exp_count));
      enable = 1'b1;
      cyc();
      check_enables("frz_issue", 2'd1);
      exp_count = exp_count + 4'd1;
      cyc();

      // SYNC waits for act_busy to drop, pulses once.
      act_busy = 1'b1;
      send("sync", mk(8'h01, 32'd0, 16'h0, 24'h0));
      cyc();
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("sync_hold%0d", k), 80'(synchronize), 80'd0);
      end
      act_busy = 1'b0;
      cyc();
      chk("sync_pulse", 80'(synchronize), 80'd1);
      cyc();
      chk("sync_once", 80'(synchronize), 80'd0);
      chk("sync_ready", 80'(instr_ready), 80'd1);

      // Undecodable opcode: sticky flag, nothing issued, next word accepted.
      send("ill", mk(8'h37, 32'd5, 16'h1, 24'h2));
      cyc();
      chk("ill_flag", 80'(illegal_opcode), 80'd1);
      check_enables("ill", 2'd0);
      chk("ill_ready", 80'(instr_ready), 80'd1);
      send("ill_next", vecs[0].instr);
      cyc();
      check_enables("ill_next", 2'd2);
      exp_count = exp_count + 4'd1;
      chk("ill_sticky", 80'(illegal_opcode), 80'd1);
      cyc();

      // Counter wraps 15 -> 0 on a 4-bit instance.
      for (int k = 0; k < 17; k++) begin
         send($sformatf("wrap%0d", k), vecs[1].instr);
         cyc();
         exp_count = exp_count + 4'd1;
         chk($sformatf("wrap%0d_count", k), 80'(issued_count), 80'(exp_count));
         cyc();
      end

      // HALT: sticky, ready stays low under a valid MATMUL.
      send("halt", mk(8'hFF, 32'd0, 16'h0, 24'h0));
      cyc();
      chk("halt_flag", 80'(halted), 80'd1);
      instr_in = vecs[0].instr;
      instr_valid = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (instr_ready !== 1'b0 || mmu_instr_enable !== 1'b0) begin
            chk($sformatf("halt_hold%0d", k), 80'({instr_ready, mmu_instr_enable}), 80'd0);
         end
         cyc();
      end
      chk("halt_ready", 80'(instr_ready), 80'd0);
      chk("halt_count", 80'(issued_count), 80'(exp_count));
      chk("halt_sticky", 80'(halted), 80'd1);
      instr_valid = 1'b0;

      // Reset clears the halt.
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      #1;
      chk("post_rst_halted", 80'(halted), 80'd0);
      chk("post_rst_ready", 80'(instr_ready), 80'd1);
      chk("post_rst_illegal", 80'(illegal_opcode), 80'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Exclusivity of issue pulses, checked every cycle.
   always @(negedge clk) begin
      if (rst && (32'(weight_instr_enable) + 32'(mmu_instr_enable) + 32'(act_instr_enable)) > 1) begin
         total++;
         bad++;
         $display("FAIL onehot_enables: got %b%b%b expected at most one",
                  weight_instr_enable, mmu_instr_enable, act_instr_enable);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
